// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32 integer core: sequences fetch, decode,
// execute, memory and writeback for one instruction at a time.

package rv32_types_pkg;

  typedef enum logic [2:0] {
    FMT_R       = 3'd0,
    FMT_I       = 3'd1,
    FMT_S       = 3'd2,
    FMT_B       = 3'd3,
    FMT_U       = 3'd4,
    FMT_J       = 3'd5,
    FMT_INVALID = 3'd7
  } inst_format_e;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SLL  = 3'b001,
    ALU_SLT  = 3'b010,
    ALU_SLTU = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SRL  = 3'b101,
    ALU_OR   = 3'b110,
    ALU_AND  = 3'b111
  } alu_funct3_e;

  typedef enum logic [6:0] {
    F7_NORMAL = 7'h00,
    F7_ALT    = 7'h20
  } alu_funct7_e;

endpackage

module multicycle_ctrl
  import rv32_types_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b0,
  parameter int RETIRE_W        = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         instr,
  input  logic                mem_done,
  input  logic                branch_taken,
  output logic                mem_req,
  output logic                mem_we,
  output logic                mem_addr_sel,
  output logic                ir_we,
  output logic                pc_we,
  output logic [1:0]          pc_src,
  output logic                alu_b_imm,
  output logic [2:0]          alu_funct3,
  output logic [6:0]          alu_funct7,
  output logic                rf_we,
  output logic [1:0]          wb_sel,
  output logic [2:0]          inst_format,
  output logic                illegal,
  output logic                halted,
  output logic [RETIRE_W-1:0] retired
);

  localparam logic [2:0] S_BOOT      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_DECODE    = 3'd2;
  localparam logic [2:0] S_EXECUTE   = 3'd3;
  localparam logic [2:0] S_MEM       = 3'd4;
  localparam logic [2:0] S_WRITEBACK = 3'd5;
  localparam logic [2:0] S_TRAP      = 3'd6;
  localparam logic [2:0] S_HALT      = 3'd7;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  logic [2:0] state_q, state_d;
  logic       retire;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       rd_zero;
  logic       is_load, is_store, is_branch, is_jal, is_jalr, is_lui;
  logic       f3_ok;

  inst_format_e fmt;
  logic         legal;
  logic [2:0]   alu_f3;
  logic [6:0]   alu_f7;
  logic         b_imm;

  logic unused_instr_bits;

  assign opcode    = instr[6:0];
  assign funct3    = instr[14:12];
  assign funct7    = instr[31:25];
  assign rd_zero   = (instr[11:7] == 5'd0);
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_jal    = (opcode == OPC_JAL);
  assign is_jalr   = (opcode == OPC_JALR);
  assign is_lui    = (opcode == OPC_LUI);
  assign unused_instr_bits = ^instr[24:15];

  // Shifts are the only funct3 codes this ALU cannot execute.
  assign f3_ok = funct3 inside {ALU_ADD, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLTU};

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; an unassigned path would infer a latch.
  always_comb begin
    fmt    = FMT_INVALID;
    legal  = 1'b0;
    alu_f3 = ALU_ADD;
    alu_f7 = F7_NORMAL;
    b_imm  = 1'b1;
    case (opcode)
      OPC_OP: begin
        fmt    = FMT_R;
        alu_f3 = funct3;
        alu_f7 = funct7;
        b_imm  = 1'b0;
        legal  = f3_ok &&
                 (funct7 == F7_NORMAL || (funct7 == F7_ALT && funct3 == ALU_ADD));
      end
      OPC_OPIMM: begin
        fmt    = FMT_I;
        alu_f3 = funct3;
        legal  = f3_ok;
      end
      OPC_LOAD, OPC_JALR: begin
        fmt   = FMT_I;
        legal = 1'b1;
      end
      OPC_STORE: begin
        fmt   = FMT_S;
        legal = 1'b1;
      end
      OPC_BRANCH: begin
        fmt    = FMT_B;
        alu_f7 = F7_ALT;
        b_imm  = 1'b0;
        legal  = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt   = FMT_U;
        legal = 1'b1;
      end
      OPC_JAL: begin
        fmt   = FMT_J;
        legal = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_BOOT:   state_d = S_FETCH;
      S_FETCH:  if (mem_done) state_d = S_DECODE;
      S_DECODE: state_d = legal ? S_EXECUTE : S_TRAP;
      S_EXECUTE: begin
        if (is_branch) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_MEM: begin
        if (mem_done) begin
          retire  = is_store;
          state_d = is_store ? S_FETCH : S_WRITEBACK;
        end
      end
      S_WRITEBACK: begin
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP:  state_d = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_BOOT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_BOOT;
      retired <= '0;
    end else begin
      state_q <= state_d;
      if (retire) retired <= retired + RETIRE_W'(1);
    end
  end

  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = 2'd0;
    alu_b_imm    = 1'b0;
    alu_funct3   = 3'd0;
    alu_funct7   = 7'd0;
    rf_we        = 1'b0;
    wb_sel       = 2'd0;
    inst_format  = 3'd0;
    illegal      = 1'b0;
    halted       = 1'b0;

    if (state_q inside {S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_TRAP})
      inst_format = fmt;

    // ALU controls stay stable through MEM and WRITEBACK, which consume its result.
    if (state_q inside {S_EXECUTE, S_MEM, S_WRITEBACK}) begin
      alu_funct3 = alu_f3;
      alu_funct7 = alu_f7;
      alu_b_imm  = b_imm;
    end

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        ir_we   = mem_done;
      end
      S_EXECUTE: begin
        if (is_branch) begin
          pc_we  = 1'b1;
          pc_src = branch_taken ? 2'd1 : 2'd0;
        end
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = is_store;
        pc_we        = is_store && mem_done;
      end
      S_WRITEBACK: begin
        rf_we  = !rd_zero;
        wb_sel = is_load ? 2'd1 : (is_jal || is_jalr) ? 2'd2 : is_lui ? 2'd3 : 2'd0;
        pc_we  = 1'b1;
        pc_src = (is_jal || is_jalr) ? 2'd1 : 2'd0;
      end
      S_TRAP: begin
        illegal = 1'b1;
        if (!HALT_ON_ILLEGAL) begin
          pc_we  = 1'b1;
          pc_src = 2'd2;
        end
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed and random instruction
// streams compared cycle by cycle against an instruction-level model.

module tb_multicycle_ctrl;

  typedef enum {P_BOOT, P_FETCH, P_DECODE, P_EXEC, P_MEM, P_WB, P_TRAP, P_HALT} phase_e;
  typedef enum {K_OP, K_OPIMM, K_LOAD, K_STORE, K_BRANCH, K_LUI, K_AUIPC,
                K_JAL, K_JALR, K_BAD} kind_e;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: trap-and-continue, 4-bit retire counter so wrap is exercised.
  logic        rst_n, mem_done, branch_taken;
  logic [31:0] instr;
  logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, alu_b_imm, rf_we, illegal, halted;
  logic [1:0]  pc_src, wb_sel;
  logic [2:0]  alu_funct3, inst_format;
  logic [6:0]  alu_funct7;
  logic [3:0]  retired;
  logic [25:0] obs;

  // Second instance: halt on illegal, default counter width.
  logic        h_rst_n, h_mem_done, h_branch_taken;
  logic [31:0] h_instr;
  logic        h_mem_req, h_mem_we, h_mem_addr_sel, h_ir_we, h_pc_we, h_alu_b_imm, h_rf_we;
  logic        h_illegal, h_halted;
  logic [1:0]  h_pc_src, h_wb_sel;
  logic [2:0]  h_alu_funct3, h_inst_format;
  logic [6:0]  h_alu_funct7;
  logic [31:0] h_retired;
  logic [25:0] obs_h;

  multicycle_ctrl #(.HALT_ON_ILLEGAL(1'b0), .RETIRE_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .mem_done(mem_done),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
    .alu_b_imm(alu_b_imm), .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
    .rf_we(rf_we), .wb_sel(wb_sel), .inst_format(inst_format), .illegal(illegal),
    .halted(halted), .retired(retired)
  );

  multicycle_ctrl #(.HALT_ON_ILLEGAL(1'b1), .RETIRE_W(32)) u_dut_halt (
    .clk(clk), .rst_n(h_rst_n), .instr(h_instr), .mem_done(h_mem_done),
    .branch_taken(h_branch_taken), .mem_req(h_mem_req), .mem_we(h_mem_we),
    .mem_addr_sel(h_mem_addr_sel), .ir_we(h_ir_we), .pc_we(h_pc_we), .pc_src(h_pc_src),
    .alu_b_imm(h_alu_b_imm), .alu_funct3(h_alu_funct3), .alu_funct7(h_alu_funct7),
    .rf_we(h_rf_we), .wb_sel(h_wb_sel), .inst_format(h_inst_format), .illegal(h_illegal),
    .halted(h_halted), .retired(h_retired)
  );

  assign obs = {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, alu_b_imm,
                alu_funct3, alu_funct7, rf_we, wb_sel, inst_format, illegal, halted};
  assign obs_h = {h_mem_req, h_mem_we, h_mem_addr_sel, h_ir_we, h_pc_we, h_pc_src,
                  h_alu_b_imm, h_alu_funct3, h_alu_funct7, h_rf_we, h_wb_sel,
                  h_inst_format, h_illegal, h_halted};

  int n_cmp = 0;
  int n_err = 0;
  int model_ret = 0;
  int model_ret_h = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic kind_e kind_of(input logic [31:0] ins);
    case (ins[6:0])
      7'b0110011: return K_OP;
      7'b0010011: return K_OPIMM;
      7'b0000011: return K_LOAD;
      7'b0100011: return K_STORE;
      7'b1100011: return K_BRANCH;
      7'b0110111: return K_LUI;
      7'b0010111: return K_AUIPC;
      7'b1101111: return K_JAL;
      7'b1100111: return K_JALR;
      default:    return K_BAD;
    endcase
  endfunction

  function automatic bit is_legal(input logic [31:0] ins);
    logic [7:0] ok_f3 = 8'hDD;  // funct3 values 0,2,3,4,6,7
    kind_e k = kind_of(ins);
    if (k == K_BAD) return 1'b0;
    if (k == K_OP)
      return ok_f3[ins[14:12]] &&
             (ins[31:25] == 7'h00 || (ins[31:25] == 7'h20 && ins[14:12] == 3'b000));
    if (k == K_OPIMM) return ok_f3[ins[14:12]];
    return 1'b1;
  endfunction

  // Format codes: R=0, I=1, S=2, B=3, U=4, J=5, INVALID=7.
  function automatic logic [2:0] fmt_of(input kind_e k);
    case (k)
      K_OP:                      return 3'd0;
      K_OPIMM, K_LOAD, K_JALR:   return 3'd1;
      K_STORE:                   return 3'd2;
      K_BRANCH:                  return 3'd3;
      K_LUI, K_AUIPC:            return 3'd4;
      K_JAL:                     return 3'd5;
      default:                   return 3'd7;
    endcase
  endfunction

  function automatic logic [25:0] exp_out(input phase_e ph, input logic [31:0] ins,
                                          input logic md, input logic tk, input bit hm);
    kind_e      k = kind_of(ins);
    logic       mreq = 0, mwe = 0, asel = 0, irwe = 0, pcwe = 0, bimm = 0;
    logic       rfwe = 0, ill = 0, hlt = 0;
    logic [1:0] psrc = 0, wsel = 0;
    logic [2:0] f3 = 0, fmt = 0;
    logic [6:0] f7 = 0;
    bit         jump = (k == K_JAL || k == K_JALR);
    if (ph inside {P_DECODE, P_EXEC, P_MEM, P_WB, P_TRAP}) fmt = fmt_of(k);
    if (ph inside {P_EXEC, P_MEM, P_WB}) begin
      case (k)
        K_OP:     begin f3 = ins[14:12]; f7 = ins[31:25]; end
        K_OPIMM:  begin f3 = ins[14:12]; bimm = 1; end
        K_BRANCH: f7 = 7'h20;
        default:  bimm = 1;
      endcase
    end
    case (ph)
      P_FETCH: begin mreq = 1; irwe = md; end
      P_EXEC:  if (k == K_BRANCH) begin pcwe = 1; psrc = tk ? 2'd1 : 2'd0; end
      P_MEM: begin
        mreq = 1; asel = 1; mwe = (k == K_STORE);
        pcwe = (k == K_STORE) && md;
      end
      P_WB: begin
        rfwe = (ins[11:7] != 0);
        wsel = (k == K_LOAD) ? 2'd1 : jump ? 2'd2 : (k == K_LUI) ? 2'd3 : 2'd0;
        pcwe = 1;
        psrc = jump ? 2'd1 : 2'd0;
      end
      P_TRAP: begin ill = 1; if (!hm) begin pcwe = 1; psrc = 2'd2; end end
      P_HALT: hlt = 1;
      default: ;
    endcase
    return {mreq, mwe, asel, irwe, pcwe, psrc, bimm, f3, f7, rfwe, wsel, fmt, ill, hlt};
  endfunction

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  // One clock: drive inputs after the rising edge, compare at the falling edge.
  task automatic step(input bit hd, input phase_e ph, input logic [31:0] ins,
                      input logic md, input logic tk, input string tag);
    if (hd) begin
      h_instr = ins; h_mem_done = md; h_branch_taken = tk; mem_done = 1'b0;
    end else begin
      instr = ins; mem_done = md; branch_taken = tk; h_mem_done = 1'b0;
    end
    @(negedge clk);
    check($sformatf("%s/%s", tag, ph.name()), hd ? 32'(obs_h) : 32'(obs),
          32'(exp_out(ph, ins, md, tk, hd)));
    @(posedge clk);
    #1;
  endtask

  task automatic check_retired(input bit hd, input string tag);
    if (hd) check({tag, "/retired"}, h_retired, 32'(model_ret_h));
    else    check({tag, "/retired"}, 32'(retired), 32'(model_ret % 16));
  endtask

  task automatic bump(input bit hd);
    if (hd) model_ret_h++;
    else    model_ret++;
  endtask

  // Expected phase sequence of one instruction, starting in FETCH.
  task automatic run_instr(input bit hd, input string tag, input logic [31:0] ins,
                           input int fw, input int mw, input logic tk);
    kind_e k = kind_of(ins);
    for (int i = 0; i <= fw; i++) step(hd, P_FETCH, ins, logic'(i == fw), rbit(), tag);
    step(hd, P_DECODE, ins, rbit(), rbit(), tag);
    if (!is_legal(ins)) begin
      step(hd, P_TRAP, ins, rbit(), rbit(), tag);
      if (hd) for (int i = 0; i < 4; i++) step(hd, P_HALT, ins, rbit(), rbit(), tag);
    end else begin
      step(hd, P_EXEC, ins, rbit(), tk, tag);
      if (k == K_BRANCH) begin
        bump(hd);
      end else if (k == K_LOAD || k == K_STORE) begin
        for (int i = 0; i <= mw; i++) step(hd, P_MEM, ins, logic'(i == mw), rbit(), tag);
        if (k == K_LOAD) step(hd, P_WB, ins, rbit(), rbit(), tag);
        bump(hd);
      end else begin
        step(hd, P_WB, ins, rbit(), rbit(), tag);
        bump(hd);
      end
    end
    check_retired(hd, tag);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r = $urandom;
    logic [6:0]  opc;
    case ($urandom_range(0, 10))
      0, 9:    opc = 7'b0110011;
      1:       opc = 7'b0010011;
      2:       opc = 7'b0000011;
      3:       opc = 7'b0100011;
      4:       opc = 7'b1100011;
      5:       opc = 7'b0110111;
      6:       opc = 7'b0010111;
      7:       opc = 7'b1101111;
      8:       opc = 7'b1100111;
      default: opc = 7'($urandom);
    endcase
    r[6:0] = opc;
    if (opc == 7'b0110011) begin
      case ($urandom_range(0, 3))
        0, 1:    r[31:25] = 7'h00;
        2:       r[31:25] = 7'h20;
        default: ;
      endcase
    end
    if ($urandom_range(0, 7) == 0) r[11:7] = 5'd0;
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; h_rst_n = 1'b0;
    instr = '0; h_instr = '0;
    mem_done = 1'b0; h_mem_done = 1'b0;
    branch_taken = 1'b0; h_branch_taken = 1'b0;

    @(negedge clk);
    check("reset/outs", 32'(obs), 32'd0);
    check("reset/retired", 32'(retired), 32'd0);
    check("reset_h/outs", 32'(obs_h), 32'd0);
    check("reset_h/retired", h_retired, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; h_rst_n = 1'b1;
    @(negedge clk);
    check("boot/outs", 32'(obs), 32'd0);
    check("boot_h/outs", 32'(obs_h), 32'd0);
    @(posedge clk); #1;

    // Directed instructions on the trap-and-continue instance.
    run_instr(0, "add",      32'h002081B3, 0, 0, 1'b0);
    run_instr(0, "sub",      32'h40208133, 1, 0, 1'b0);
    run_instr(0, "bad_f3",   32'h40209133, 0, 0, 1'b0);
    run_instr(0, "load",     32'h0000A183, 0, 3, 1'b0);
    run_instr(0, "store",    32'h0030A023, 2, 1, 1'b0);
    run_instr(0, "beq_t",    32'h00208463, 0, 0, 1'b1);
    run_instr(0, "beq_nt",   32'h00208463, 0, 0, 1'b0);
    run_instr(0, "addi_x0",  32'h00000013, 0, 0, 1'b0);
    run_instr(0, "slli",     32'h00209093, 0, 0, 1'b0);
    run_instr(0, "jal",      32'h008000EF, 0, 0, 1'b0);
    run_instr(0, "jalr",     32'h000080E7, 0, 0, 1'b0);
    run_instr(0, "lui",      32'h123451B7, 0, 0, 1'b0);
    run_instr(0, "auipc",    32'h00001197, 0, 0, 1'b0);
    run_instr(0, "invalid",  32'hFFFFFFFF, 0, 0, 1'b0);

    for (int n = 0; n < 250; n++)
      run_instr(0, $sformatf("rnd%0d", n), rand_instr(),
                $urandom_range(0, 3), $urandom_range(0, 3), rbit());

    // Asynchronous reset while a load waits in MEM.
    if (model_ret % 16 == 0) run_instr(0, "pre_rst", 32'h002081B3, 0, 0, 1'b0);
    step(0, P_FETCH,  32'h0000A183, 1'b1, 1'b0, "ld_rst");
    step(0, P_DECODE, 32'h0000A183, 1'b0, 1'b0, "ld_rst");
    step(0, P_EXEC,   32'h0000A183, 1'b0, 1'b0, "ld_rst");
    step(0, P_MEM,    32'h0000A183, 1'b0, 1'b0, "ld_rst");
    rst_n = 1'b0;
    #1;
    check("mid_mem_rst/outs", 32'(obs), 32'd0);
    check("mid_mem_rst/retired", 32'(retired), 32'd0);
    model_ret = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(0, P_BOOT, 32'h002081B3, 1'b1, 1'b0, "reboot");
    run_instr(0, "add_after_rst", 32'h002081B3, 0, 0, 1'b0);

    // Halt-on-illegal instance.
    run_instr(1, "h_add", 32'h002081B3, 0, 0, 1'b0);
    run_instr(1, "h_bad", 32'hFFFFFFFF, 1, 0, 1'b0);
    h_rst_n = 1'b0;
    #1;
    check("h_rst/outs", 32'(obs_h), 32'd0);
    check("h_rst/retired", h_retired, 32'd0);
    model_ret_h = 0;
    @(posedge clk); #1;
    h_rst_n = 1'b1;
    step(1, P_BOOT, 32'h002081B3, 1'b0, 1'b0, "h_reboot");
    run_instr(1, "h_add2", 32'h002081B3, 0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the RV32 integer core. It sequences one instruction at a time through fetch, decode, execute, memory and writeback.
- Drives the IR, PC, register file, ALU and memory-port control signals.
- Classifies each instruction into an inst_format_e value and drives ALU operation codes as alu_funct3_e/alu_funct7_e from the types package.
- Traps on encodings the ALU cannot execute. Counts retired instructions.

Parameters:
- HALT_ON_ILLEGAL, 0, 1: an illegal instruction parks the FSM in HALT until reset. 0: redirect to the trap vector and continue.
- RETIRE_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- instr  in  32  IR contents (valid from DECODE onward)
- mem_done  in  1  memory completes the current request this cycle (read data valid)
- branch_taken  in  1  comparator result for the current B-type instruction, valid in EXECUTE
- mem_req  out  1  memory request
- mem_we  out  1  store strobe, qualified by mem_req
- mem_addr_sel  out  1  0 = PC, 1 = ALU result
- ir_we  out  1  load IR from memory read data
- pc_we  out  1  update PC
- pc_src  out  2  0 = PC+4, 1 = ALU target, 2 = trap vector
- alu_b_imm  out  1  ALU operand B = immediate
- alu_funct3  out  3  alu_funct3_e
- alu_funct7  out  7  alu_funct7_e
- rf_we  out  1  register-file write
- wb_sel  out  2  0 = ALU, 1 = memory data, 2 = PC+4, 3 = immediate
- inst_format  out  3  inst_format_e of the current instruction
- illegal  out  1  one-cycle pulse in TRAP
- halted  out  1  FSM is in HALT
- retired  out  RETIRE_W  count of retired instructions

Behaviour:
- States: BOOT, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP, HALT.
- State is registered. Outputs are combinational from state and instr. retired is registered.
- Reset (async, any state, mid-instruction included):
  - state = BOOT, retired = 0.
  - All outputs are 0 in BOOT.
  - BOOT always goes to FETCH on the next clock.
- FETCH: mem_req=1, mem_addr_sel=0. Hold until mem_done. On mem_done: ir_we=1, go to DECODE.
- DECODE (1 cycle): classify instr[6:0].
  - 0110011 -> R
  - 0010011, 0000011, 1100111 -> I
  - 0100011 -> S
  - 1100011 -> B
  - 0110111, 0010111 -> U
  - 1101111 -> J
  - anything else -> INVALID, go to TRAP.
- Legality (otherwise go to TRAP):
  - R-type: funct3 must be in {000, 111, 110, 100, 010, 011}. funct7 must be NORMAL, or ALT only with funct3=000.
  - OP-IMM: funct3 must be in the same set; funct7 is forced to NORMAL.
- ALU codes:
  - R: instr funct3/funct7 passed through.
  - OP-IMM: funct3 passed through, funct7 = NORMAL, alu_b_imm=1.
  - Load/store/JALR/AUIPC/JAL target: ADD/NORMAL, alu_b_imm=1.
  - B: ADD/ALT (subtract), alu_b_imm=0.
- EXECUTE:
  - R, OP-IMM, U, J, JALR -> WRITEBACK.
  - Load/store -> MEM.
  - B: pc_we=1, pc_src = branch_taken ? 1 : 0, increment retired, go to FETCH.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=1 for stores. Hold until mem_done.
  - Store: pc_we=1, pc_src=0, increment retired, go to FETCH.
  - Load: go to WRITEBACK.
- WRITEBACK:
  - rf_we=1 unless instr[11:7]==0.
  - wb_sel: load=1, JAL/JALR=2, LUI=3, else 0.
  - pc_we=1, pc_src = 1 for JAL/JALR, else 0.
  - Increment retired, go to FETCH.
- TRAP (1 cycle): illegal=1. Then:
  - HALT_ON_ILLEGAL=0: pc_we=1, pc_src=2, go to FETCH.
  - HALT_ON_ILLEGAL=1: go to HALT (halted=1, all other outputs 0) until reset.
- Illegal instructions never increment retired.
- retired wraps from 2^RETIRE_W-1 to 0.
- mem_done outside FETCH/MEM is ignored.
- Latency with mem_done in the same cycle as the request:
  - ALU/U/J: 4 cycles
  - load: 5 cycles
  - store: 4 cycles
  - branch: 3 cycles

Test Plan:
- Reset, release, mem_done tied 1, instr=0x002081B3 (add x3,x1,x2) -> BOOT, FETCH, DECODE, EXECUTE (alu_funct3=000, alu_funct7=0x00), WRITEBACK (rf_we=1, wb_sel=0, pc_we=1); retired=1 after 5 cycles.
- instr=0x40208133 (sub) -> alu_funct7=0x20. instr=0x40209133 (funct3=001) -> illegal pulse, pc_src=2, retired unchanged.
- Load 0x0000A183 with mem_done held low 3 cycles in MEM -> mem_req=1 and mem_addr_sel=1 held for 3 cycles, then WRITEBACK with wb_sel=1. Store 0x0030A023 -> mem_we=1, no rf_we.
- Branch 0x00208463 -> EXECUTE uses ADD/ALT. branch_taken=1 gives pc_src=1; branch_taken=0 gives pc_src=0. 3 cycles per branch.
- HALT_ON_ILLEGAL=1, instr=0xFFFFFFFF -> TRAP, then halted=1 persistently. Assert rst_n low mid-MEM -> outputs 0 immediately, retired=0.
- Preload retired to 2^RETIRE_W-1 (RETIRE_W=4), retire one instruction -> retired=0.
